i2c_req_arbiter: RTL and testbench

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter granting four requesters access to a single I2C master.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYC = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [27:0]  req_addr,
  input  logic [127:0] req_data,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic         busy,
  output logic         m_start,
  output logic [6:0]   m_addr,
  output logic [31:0]  m_data,
  input  logic         m_ready,
  input  logic         m_stop,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_STOP = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  ptr_r;
  logic [1:0]  winner_r;
  logic [3:0]  gnt_r;
  logic [3:0]  done_r;
  logic        busy_r;
  logic        m_start_r;
  logic [6:0]  m_addr_r;
  logic [31:0] m_data_r;
  logic        err_r;

  logic [1:0]  pick_s;
  logic        pick_vld_s;
  logic [1:0]  idx_s;
  logic        stop_s;
  logic        tmo_s;
  logic        fin_s;

  // Round-robin pick: scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_s     = 2'd0;
    pick_vld_s = 1'b0;
    idx_s      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx_s = ptr_r + 2'(i);
      if (req[idx_s]) begin
        pick_s     = idx_s;
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog: zero while idle, counts every cycle spent waiting on the master.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      wd_cnt_r <= '0;
    end else if (state_r == LAUNCH || state_r == WAIT_STOP) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Firing one count early lands err exactly TIMEOUT_CYC cycles after LAUNCH entry.
  assign tmo_s = (state_r == LAUNCH || state_r == WAIT_STOP) &&
                 (wd_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_s = 1'b0;
`endif

  assign stop_s = (state_r == WAIT_STOP) && m_stop;
  assign fin_s  = stop_s || tmo_s;

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      winner_r  <= 2'd0;
      gnt_r     <= 4'b0000;
      done_r    <= 4'b0000;
      busy_r    <= 1'b0;
      m_start_r <= 1'b0;
      m_addr_r  <= 7'd0;
      m_data_r  <= 32'd0;
      err_r     <= 1'b0;
    end else if (fin_s) begin
      // A normal STOP takes precedence over a coincident watchdog expiry.
      state_r   <= DONE;
      gnt_r     <= 4'b0000;
      m_start_r <= 1'b0;
      done_r    <= 4'b0001 << winner_r;
      err_r     <= ~stop_s;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 4'b0000;
          err_r  <= 1'b0;
          if (pick_vld_s) begin
            state_r   <= LAUNCH;
            winner_r  <= pick_s;
            gnt_r     <= 4'b0001 << pick_s;
            busy_r    <= 1'b1;
            m_start_r <= 1'b1;
            m_addr_r  <= req_addr[7 * int'(pick_s) +: 7];
            m_data_r  <= req_data[32 * int'(pick_s) +: 32];
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          if (m_ready) begin
            state_r   <= WAIT_STOP;
            m_start_r <= 1'b0;
          end else begin
            state_r <= LAUNCH;
          end
        end
        WAIT_STOP: begin
          state_r <= WAIT_STOP;
        end
        DONE: begin
          state_r <= IDLE;
          ptr_r   <= winner_r + 2'd1;
          done_r  <= 4'b0000;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= 4'b0000;
          done_r    <= 4'b0000;
          busy_r    <= 1'b0;
          m_start_r <= 1'b0;
          err_r     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign m_start = m_start_r;
  assign m_addr  = m_addr_r;
  assign m_data  = m_data_r;
  assign err     = err_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a transaction-level reference model is checked
// every cycle, plus literal expectations for the key scenarios.
module tb_i2c_req_arbiter;
  localparam int TO = 96;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [27:0]  req_addr = 28'd0;
  logic [127:0] req_data = 128'd0;
  logic [3:0]   gnt, done;
  logic         busy, m_start, err;
  logic [6:0]   m_addr;
  logic [31:0]  m_data;
  logic         m_ready = 1'b0;
  logic         m_stop = 1'b0;

  i2c_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .m_start(m_start), .m_addr(m_addr),
    .m_data(m_data), .m_ready(m_ready), .m_stop(m_stop), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the master, whether it accepted, how long it has run.
  int          md_owner = -1;
  bit          md_acc = 1'b0;
  int          md_age = 0;
  int          md_ptr = 0;
  bit          md_fin = 1'b0;
  logic [3:0]  exp_gnt = 4'd0, exp_done = 4'd0;
  logic        exp_busy = 1'b0, exp_mstart = 1'b0, exp_err = 1'b0;
  logic [6:0]  exp_addr = 7'd0;
  logic [31:0] exp_data = 32'd0;

  function automatic int rr(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_owner <= -1; md_acc <= 1'b0; md_age <= 0; md_ptr <= 0; md_fin <= 1'b0;
      exp_gnt <= 4'd0; exp_done <= 4'd0; exp_busy <= 1'b0; exp_mstart <= 1'b0;
      exp_addr <= 7'd0; exp_data <= 32'd0; exp_err <= 1'b0;
    end else if (md_fin) begin
      md_fin <= 1'b0; exp_done <= 4'd0; exp_err <= 1'b0; exp_busy <= 1'b0;
    end else if (md_owner < 0) begin
      if (req != 4'd0) begin
        md_owner   <= rr(req, md_ptr);
        md_acc     <= 1'b0;
        md_age     <= 0;
        exp_gnt    <= 4'(1 << rr(req, md_ptr));
        exp_busy   <= 1'b1;
        exp_mstart <= 1'b1;
        exp_addr   <= req_addr[7 * rr(req, md_ptr) +: 7];
        exp_data   <= req_data[32 * rr(req, md_ptr) +: 32];
      end
    end else if ((md_acc && m_stop) || (TIMEOUT_ON && md_age + 1 == TO)) begin
      exp_done   <= 4'(1 << md_owner);
      exp_err    <= !(md_acc && m_stop);
      exp_gnt    <= 4'd0;
      exp_mstart <= 1'b0;
      md_ptr     <= (md_owner + 1) % 4;
      md_owner   <= -1;
      md_fin     <= 1'b1;
    end else begin
      md_age <= md_age + 1;
      if (!md_acc && m_ready) begin
        md_acc     <= 1'b1;
        exp_mstart <= 1'b0;
      end
    end
  end

  int   n_checks = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;
  int   starts = 0;
  int   done_cnt[4] = '{0, 0, 0, 0};
  int   gq[$];
  logic prev_mstart = 1'b0;
  logic [3:0] prev_gnt = 4'd0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock step: compare against the model and record transaction events.
  task automatic tick();
    @(negedge clk);
    if (cmp_en) begin
      chk("gnt", gnt, exp_gnt);
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("m_start", m_start, exp_mstart);
      chk("m_addr", m_addr, exp_addr);
      chk("m_data", m_data, exp_data);
      chk("err", err, exp_err);
    end
    if (m_start && !prev_mstart) starts++;
    if (gnt != 4'd0 && prev_gnt == 4'd0)
      for (int i = 0; i < 4; i++) if (gnt[i]) gq.push_back(i);
    for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    prev_mstart = m_start;
    prev_gnt    = gnt;
  endtask

  task automatic serve(input int acc_dly, input int stop_dly);
    int n = 0;
    while (!m_start && n < 20) begin tick(); n++; end
    chk("launch_seen", m_start, 1'b1);
    repeat (acc_dly) tick();
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    repeat (stop_dly) tick();
    m_stop = 1'b1; tick(); m_stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    int d1;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7]   = 7'h10 + 7'(i);
      req_data[32*i +: 32] = 32'h1111_0000 * 32'(i + 1);
    end
    req_addr[14 +: 7]  = 7'h78;
    req_data[64 +: 32] = 32'hA5A5_0F0F;

    tick(); cmp_en = 1'b1;
    tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mdata", m_data, 32'd0);
    reset = 1'b0; tick();

    // Single request from requester 2, dropped after grant; req noise mid-transaction.
    req = 4'b0100; tick(); req = 4'b0000;
    chk("t34_gnt", gnt, 4'b0100);
    chk("t34_maddr", m_addr, 7'h78);
    chk("t34_mdata", m_data, 32'hA5A5_0F0F);
    chk("t34_mstart", m_start, 1'b1);
    tick();
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t34_mstart_drop", m_start, 1'b0);
    req = 4'b1011; repeat (3) tick();
    req = 4'b0000; m_stop = 1'b1; tick(); m_stop = 1'b0;
    chk("t34_done", done, 4'b0100);
    chk("t34_gnt_clr", gnt, 4'b0000);
    tick();
    chk("t34_done_once", done, 4'b0000);
    chk("t34_idle", busy, 1'b0);

    // Fairness with all four requesting.
    do_reset(); gq.delete();
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) serve(t % 3, 1 + t % 2);
    req = 4'b0000; repeat (3) tick();
    chk("t35_ngrants", gq.size(), 8);
    for (int t = 0; t < 8 && t < gq.size(); t++) chk("t35_order", gq[t], exp_order[t]);
    for (int i = 0; i < 4; i++) chk("t35_dones", done_cnt[i], 2);

    // One-cycle pulse on requester 1.
    starts = 0; d1 = done_cnt[1];
    req = 4'b0010; tick(); req = 4'b0000;
    chk("t36_gnt", gnt, 4'b0010);
    serve(1, 2);
    repeat (4) tick();
    chk("t36_starts", starts, 1);
    chk("t36_done", done_cnt[1], d1 + 1);

    // Reset ten cycles into WAIT_STOP.
    d1 = done_cnt[2];
    req = 4'b0100; tick(); req = 4'b0000;
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    repeat (9) tick();
    reset = 1'b1; tick();
    chk("t37_gnt", gnt, 4'b0000);
    chk("t37_busy", busy, 1'b0);
    chk("t37_mstart", m_start, 1'b0);
    chk("t37_maddr", m_addr, 7'd0);
    chk("t37_mdata", m_data, 32'd0);
    chk("t37_done", done, 4'b0000);
    chk("t37_err", err, 1'b0);
    reset = 1'b0; tick();
    chk("t37_no_done", done_cnt[2], d1);
    req = 4'b1111; tick(); req = 4'b0000;
    chk("t37_ptr0", gnt, 4'b0001);
    serve(0, 1);
    tick();

    // Master strobes while idle are ignored.
    m_ready = 1'b1; m_stop = 1'b1; repeat (2) tick();
    m_ready = 1'b0; m_stop = 1'b0; tick();
    chk("t27_idle", busy, 1'b0);

    // Master never responds.
    req = 4'b1000; tick(); req = 4'b0000;
    chk("t38_gnt", gnt, 4'b1000);
`ifdef I2C_ARB_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("t38_err_early", err, 1'b0);
    tick();
    chk("t38_err", err, 1'b1);
    chk("t38_done", done, 4'b1000);
    chk("t38_gnt_clr", gnt, 4'b0000);
    tick();
    chk("t38_err_once", err, 1'b0);
    chk("t38_idle", busy, 1'b0);
`else
    repeat (1000) tick();
    chk("t39_busy", busy, 1'b1);
    chk("t39_err", err, 1'b0);
    chk("t39_gnt", gnt, 4'b1000);
    chk("t39_mstart", m_start, 1'b1);
`endif
    do_reset(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
